// File: rtl/definitions_pack.sv
// definitions_pack: shared types and constants for the vector-magnitude block.
//   fixed           : Q16.16 two's-complement scalar
//   FW, FRAC        : width and fractional bits of fixed
//   FIXED_MAX       : largest positive fixed value
//   vec_mag_state_t : controller states of vec_magnitude
`ifndef DEFINITIONS_PACK_SV
`define DEFINITIONS_PACK_SV

// Integer literal to fixed, e.g. `FIXED(3) == 32'h0003_0000.
`define FIXED(n) (32'((n) * 65536))

package definitions_pack;

    localparam int FW   = 32;
    localparam int FRAC = 16;

    typedef logic [FW-1:0] fixed;

    localparam fixed FIXED_MAX = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MAC      = 3'd1,
        SQ_START = 3'd2,
        SQ_WAIT  = 3'd3,
        DONE     = 3'd4
    } vec_mag_state_t;

endpackage

`endif

// File: rtl/vec_magnitude_sq_acc.sv
// fixed_sq_acc: squares one fixed component per enabled cycle, drops the
// FRAC fractional bits of the product and adds the result into an
// (FW+2)-bit unsigned accumulator that saturates at all-ones.
//   clock, reset : clock, asynchronous active-high reset
//   clear        : zero the accumulator (wins over en)
//   en           : accumulate comp*comp >> FRAC this cycle
//   comp         : fixed operand
//   acc          : running sum of squares
module fixed_sq_acc
    import definitions_pack::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    input  fixed          comp,
    output logic [FW+1:0] acc
);

    localparam logic [2*FW-1:0] ACC_MAX = {{(FW-2){1'b0}}, {(FW+2){1'b1}}};

    logic signed [2*FW-1:0] prod;
    logic        [2*FW-1:0] shifted;
    logic        [2*FW-1:0] sum;
    logic        [FW+1:0]   acc_nx;

    // A square is never negative, so the signed product can be treated as
    // unsigned; the sum cannot overflow 2*FW bits (48-bit term + 34-bit acc).
    assign prod    = $signed(comp) * $signed(comp);
    assign shifted = $unsigned(prod) >> FRAC;
    assign sum     = {{(FW-2){1'b0}}, acc} + shifted;
    assign acc_nx  = (sum > ACC_MAX) ? ACC_MAX[FW+1:0] : sum[FW+1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nx;
        end
    end

endmodule

// File: rtl/vec_magnitude.sv
// vec_magnitude: computes |(x,y,z)| for fixed vectors. The sum of squares is
// built over three cycles with one shared multiplier, then handed to the
// external mSqrt unit over a start/ready handshake.
//   clock, reset  : clock, asynchronous active-high reset
//   start, x/y/z  : one-cycle request and vector, sampled in IDLE only
//   mag, done     : result (held) and one-cycle update pulse
//   busy          : operation in progress
//   sat, err      : sum-of-squares saturated / sqrt timeout, valid with done
//   sq_start/sq_a : request pulse and operand to mSqrt
//   sq_b/sq_ready : mSqrt result and result-valid level
//   dbg_state     : current controller state
// Handshake: sq_start is a one-cycle pulse with sq_a stable from that cycle
// through capture; sq_b is taken on a cycle where sq_ready=1, except the
// first SQ_WAIT cycle, where ready may still be left over from the last run.
module vec_magnitude
    import definitions_pack::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  fixed           x,
    input  fixed           y,
    input  fixed           z,
    output fixed           mag,
    output logic           done,
    output logic           busy,
    output logic           sat,
    output logic           err,
    output logic           sq_start,
    output fixed           sq_a,
    input  fixed           sq_b,
    input  logic           sq_ready,
    output vec_mag_state_t dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    vec_mag_state_t state, state_nx;
    logic [1:0]     k_q;
    fixed           cx_q, cy_q, cz_q;
    fixed           comp;
    logic [CW-1:0]  cnt_q;
    fixed           sq_a_q;
    fixed           sq_a_nx;
    logic [FW+1:0]  acc;
    logic           acc_over;
    logic           accept;
    logic           cap;
    logic           tmo;

    assign accept   = (state == IDLE) && start;
    assign cap      = (state == SQ_WAIT) && (cnt_q != '0) && sq_ready;
    assign tmo      = (state == SQ_WAIT) && !cap && (cnt_q == CW'(TIMEOUT - 1));
    assign acc_over = acc > {2'b00, FIXED_MAX};
    assign sq_a_nx  = acc_over ? FIXED_MAX : acc[FW-1:0];

    always_comb begin
        comp = cx_q;
        case (k_q)
            2'd1:    comp = cy_q;
            2'd2:    comp = cz_q;
            default: comp = cx_q;
        endcase
    end

    fixed_sq_acc u_acc (
        .clock (clock),
        .reset (reset),
        .clear (accept),
        .en    (state == MAC),
        .comp  (comp),
        .acc   (acc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = MAC;
            MAC:      if (k_q == 2'd2) state_nx = SQ_START;
            SQ_START: state_nx = SQ_WAIT;
            SQ_WAIT:  if (cap || tmo) state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            k_q    <= '0;
            cx_q   <= '0;
            cy_q   <= '0;
            cz_q   <= '0;
            cnt_q  <= '0;
            sq_a_q <= '0;
            mag    <= '0;
            sat    <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (accept) begin
                cx_q <= x;
                cy_q <= y;
                cz_q <= z;
                k_q  <= '0;
                sat  <= 1'b0;
                err  <= 1'b0;
            end
            if (state == MAC) begin
                k_q <= k_q + 2'd1;
            end
            if (state == SQ_START) begin
                sq_a_q <= sq_a_nx;
                sat    <= acc_over;
                cnt_q  <= '0;
            end
            if (state == SQ_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cap) begin
                mag <= sq_b;
            end else if (tmo) begin
                mag <= '0;
                err <= 1'b1;
            end
        end
    end

    // sq_a is driven straight from the accumulator in the request cycle so
    // the operand is stable from the sq_start cycle onward.
    assign sq_a      = (state == SQ_START) ? sq_a_nx : sq_a_q;
    assign sq_start  = (state == SQ_START);
    assign done      = (state == DONE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_vec_magnitude.sv
module tb_vec_magnitude;
  import definitions_pack::*;

  localparam int TIMEOUT = 64;
  localparam int SQ_LAT  = 15;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic           start = 1'b0;
  fixed           x = '0, y = '0, z = '0;
  fixed           mag, sq_a, sq_b;
  logic           done, busy, sat, err, sq_start, sq_ready;
  vec_mag_state_t dbg_state;

  vec_magnitude #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start),
    .x(x), .y(y), .z(z),
    .mag(mag), .done(done), .busy(busy), .sat(sat), .err(err),
    .sq_start(sq_start), .sq_a(sq_a), .sq_b(sq_b), .sq_ready(sq_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural mSqrt ----------------
  // mode 0: ready rises SQ_LAT cycles after sq_start, holds until next start
  // mode 1: ready never rises
  // mode 2: ready stuck high; sq_b shows a stale value for one cycle
  int   sq_mode = 0;
  int   sq_cnt  = 0;
  fixed sq_res  = '0;
  logic sq_pend = 1'b0;

  function automatic fixed isqrt_q16(input fixed a);
    logic [63:0] v, t;
    logic [31:0] r;
    v = {16'd0, a, 16'd0};
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      t = {32'd0, r | (32'd1 << i)};
      if (t * t <= v) r = t[31:0];
    end
    return r;
  endfunction

  always @(posedge clock) begin
    if (sq_start) begin
      sq_res   <= isqrt_q16(sq_a);
      sq_cnt   <= SQ_LAT;
      sq_pend  <= 1'b1;
      sq_ready <= (sq_mode == 2);
      if (sq_mode == 2) sq_b <= 32'hDEAD_BEEF;
    end else begin
      if (sq_mode == 2 && sq_pend) begin
        sq_b    <= sq_res;
        sq_pend <= 1'b0;
      end else if (sq_mode == 0 && sq_cnt != 0) begin
        sq_cnt <= sq_cnt - 1;
        if (sq_cnt == 1) begin
          sq_ready <= 1'b1;
          sq_b     <= sq_res;
          sq_pend  <= 1'b0;
        end
      end
      if (sq_mode == 1) sq_ready <= 1'b0;
      if (sq_mode == 2) sq_ready <= 1'b1;
    end
  end

  initial begin
    sq_ready = 1'b0;
    sq_b     = '0;
  end

  // ---------------- monitors ----------------
  int   done_cnt = 0;
  int   sqs_cnt  = 0;
  fixed sqa_seen = '0;
  always @(negedge clock) begin
    if (done) done_cnt++;
    if (sq_start) begin
      sqs_cnt++;
      sqa_seen = sq_a;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [FW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // ---------------- driver ----------------
  int   lat;
  fixed r_mag;
  logic r_sat, r_err;

  // Issues one start, optionally a second start mid-operation, and waits
  // (bounded) for done. lat counts falling edges from acceptance to done.
  task automatic run_op(input fixed vx, input fixed vy, input fixed vz, input bit restart);
    @(negedge clock);
    x = vx; y = vy; z = vz; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    x = 32'h1234_5678; y = 32'h1234_5678; z = 32'h1234_5678;
    lat = 1;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    while (!done && lat < 300) begin
      @(negedge clock);
      lat++;
      if (restart && lat == 4) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    if (!done) $display("FAIL done_timeout: no done within %0d cycles", lat);
    r_mag = mag; r_sat = sat; r_err = err;
    @(negedge clock);
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic within1(input string tag, input fixed obs, input fixed exp);
    logic ok;
    ok = (obs >= exp - 1) && (obs <= exp + 1);
    check(tag, ok ? exp : obs, exp);
  endtask

  int d0, s0;

  initial begin
    // reset state
    #12;
    check("rst_mag", mag, 32'd0);
    check("rst_flags", {26'd0, done, busy, sat, err, sq_start, 1'b0}, 32'd0);
    check("rst_sqa", sq_a, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 3-4-0 -> 5
    d0 = done_cnt; s0 = sqs_cnt;
    run_op(32'h0003_0000, 32'h0004_0000, 32'h0, 1'b0);
    exp_q.push_back(32'h0005_0000);
    check("v340_sqa", sqa_seen, 32'h0019_0000);
    check("v340_mag", r_mag, exp_q.pop_front());
    check("v340_sat", {31'd0, r_sat}, 32'd0);
    check("v340_err", {31'd0, r_err}, 32'd0);
    check("v340_lat", lat, 6 + SQ_LAT);
    check("v340_done1", done_cnt - d0, 32'd1);

    // -2,0,0 -> 2
    run_op(32'hFFFE_0000, 32'h0, 32'h0, 1'b0);
    check("vm2_sqa", sqa_seen, 32'h0004_0000);
    check("vm2_mag", r_mag, 32'h0002_0000);

    // 1,1,1 -> sqrt(3), with an ignored second start while busy
    d0 = done_cnt; s0 = sqs_cnt;
    run_op(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b1);
    check("v111_sqa", sqa_seen, 32'h0003_0000);
    within1("v111_mag", r_mag, 32'h0001_BB67);
    repeat (30) @(negedge clock);
    check("v111_one_done", done_cnt - d0, 32'd1);
    check("v111_one_sqs", sqs_cnt - s0, 32'd1);

    // saturation
    run_op(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0);
    check("vsat_sqa", sqa_seen, 32'h7FFF_FFFF);
    check("vsat_sat", {31'd0, r_sat}, 32'd1);
    check("vsat_err", {31'd0, r_err}, 32'd0);
    within1("vsat_mag", r_mag, 32'h00B5_04F3);

    // zero vector; sat cleared by the new start
    run_op(32'h0, 32'h0, 32'h0, 1'b0);
    check("vzero_sqa", sqa_seen, 32'h0);
    check("vzero_mag", r_mag, 32'h0);
    check("vzero_sat", {31'd0, r_sat}, 32'd0);

    // timeout: ready never rises
    sq_mode = 1;
    d0 = done_cnt; s0 = sqs_cnt;
    run_op(32'h0003_0000, 32'h0004_0000, 32'h0, 1'b0);
    check("to_err", {31'd0, r_err}, 32'd1);
    check("to_mag", r_mag, 32'h0);
    check("to_lat_ge", {31'd0, lat >= TIMEOUT}, 32'd1);
    check("to_one_sqs", sqs_cnt - s0, 32'd1);

    // ready stuck high: first-cycle ready ignored, capture on the second
    sq_mode = 2;
    run_op(32'h0003_0000, 32'h0004_0000, 32'h0, 1'b0);
    check("hi_mag", r_mag, 32'h0005_0000);
    check("hi_err", {31'd0, r_err}, 32'd0);
    check("hi_lat", lat, 7);

    // asynchronous reset during SQ_WAIT
    sq_mode = 0;
    @(negedge clock);
    x = 32'h0003_0000; y = 32'h0004_0000; z = 32'h0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    while (dbg_state != SQ_WAIT && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    check("rw_reached_wait", {29'd0, dbg_state}, {29'd0, SQ_WAIT});
    repeat (3) @(negedge clock);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("rw_mag", mag, 32'd0);
    check("rw_flags", {26'd0, done, busy, sat, err, sq_start, 1'b0}, 32'd0);
    check("rw_sqa", sq_a, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (25) @(negedge clock);
    check("rw_no_done", done_cnt - d0, 32'd0);
    run_op(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0);
    within1("rw_next_mag", r_mag, 32'h0001_BB67);
    check("rw_next_err", {31'd0, r_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
